// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Occupancy after one cycle; callers narrow the result to their count width.
    function automatic logic [31:0] next_count(input logic [31:0] count, input fifo_op_e op);
        case (op)
            OP_PUSH: next_count = count + 32'd1;
            OP_POP:  next_count = count - 32'd1;
            default: next_count = count;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write, asynchronous (fall-through) read.
module sync_fifo_mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock ready/valid FIFO using full 2**ADDR_WIDTH depth via wrap-bit pointers.
// Define SYNC_FIFO_WATERMARK_EN to add the high_water occupancy output.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    output logic                  ready_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    output logic [ADDR_WIDTH:0]   high_water
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_T  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_T = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [ADDR_WIDTH:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                active_q, active_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                full, empty, push, pop;
    fifo_op_e            op;

    always_comb begin
        full      = (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]) &&
                    (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]);
        empty     = (w_ptr_q == r_ptr_q);
        ready_in  = active_q && !full;
        valid_out = active_q && !empty;
        push      = ready_in && valid_in;
        pop       = ready_out && valid_out;
        op        = fifo_op_e'({pop, push});

        active_d = 1'b1;
        w_ptr_d  = w_ptr_q;
        r_ptr_d  = r_ptr_q;
        count_d  = (ADDR_WIDTH + 1)'(next_count(32'(count_q), op));
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (push) w_ptr_d = w_ptr_q + 1'b1;
            if (pop)  r_ptr_d = r_ptr_q + 1'b1;
        end
        // Flags follow the next count, so a flush lands them on their reset values too.
        afull_d  = (count_d >= AFULL_T);
        aempty_d = (count_d <= AEMPTY_T);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            count_q  <= count_d;
            active_q <= active_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [ADDR_WIDTH:0] high_water_q, high_water_d;

    always_comb begin
        high_water_d = high_water_q;
        if (flush) begin
            high_water_d = '0;
        end else if (count_d > high_water_q) begin
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water = high_water_q;
`endif

    sync_fifo_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (push && !flush),
        .waddr(w_ptr_q[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .raddr(r_ptr_q[ADDR_WIDTH-1:0]),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, directed corner cases, randomized traffic vs queue model.
module tb_sync_fifo;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          ready_in;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
`ifdef SYNC_FIFO_WATERMARK_EN
    logic [AW:0]   high_water;
`endif

    always #5 clk = ~clk;

    sync_fifo #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .ready_in    (ready_in),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`ifdef SYNC_FIFO_WATERMARK_EN
        ,
        .high_water  (high_water)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of stored words plus the "running" flag.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_hw     = 0;
    bit         aa_banned = 1'b0;
    bit         seen_aa   = 1'b0;

    typedef struct {
        bit         vin;
        logic [7:0] din;
        bit         rout;
        bit         fl;
        int         e_count;
        bit         e_valid;
        bit         e_ready;
        logic [7:0] e_data;
        bit         e_af;
        bit         e_ae;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = mq.size();
        check("ready_in",     32'(ready_in),     32'(m_active && sz < DEPTH));
        check("valid_out",    32'(valid_out),    32'(m_active && sz > 0));
        check("count",        32'(count),        32'(sz));
        check("almost_full",  32'(almost_full),  32'(sz >= AF));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        if (m_active && sz > 0) check("data_out", 32'(data_out), 32'(mq[0]));
`ifdef SYNC_FIFO_WATERMARK_EN
        check("high_water",   32'(high_water),   32'(m_hw));
`endif
        if (aa_banned && valid_out === 1'b1 && data_out === 8'hAA) seen_aa = 1'b1;
    endtask

    task automatic cycle(input bit vin, input logic [7:0] din, input bit rout, input bit fl);
        bit do_push, do_pop;
        valid_in  = vin;
        data_in   = din;
        ready_out = rout;
        flush     = fl;
        do_push = vin && m_active && mq.size() < DEPTH;
        do_pop  = rout && m_active && mq.size() > 0;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_hw = 0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(din);
            if (mq.size() > m_hw) m_hw = mq.size();
        end
        m_active = 1'b1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill rows: push 1..9 with no pops; pop rows: drain all 8.
        for (int k = 1; k <= 9; k++) begin
            int c;
            c = (k < DEPTH) ? k : DEPTH;
            vt[k-1] = '{vin: 1'b1, din: 8'(k), rout: 1'b0, fl: 1'b0, e_count: c, e_valid: 1'b1,
                        e_ready: (c < DEPTH), e_data: 8'h01, e_af: (c >= AF), e_ae: (c <= AE)};
        end
        for (int j = 1; j <= 8; j++) begin
            int c;
            c = DEPTH - j;
            vt[8+j] = '{vin: 1'b0, din: 8'h00, rout: 1'b1, fl: 1'b0, e_count: c, e_valid: (c > 0),
                        e_ready: 1'b1, e_data: 8'(j + 1), e_af: (c >= AF), e_ae: (c <= AE)};
        end

        reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        #12;
        check_all();
        reset_n = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(ready_in), 32'd0);
        cycle(0, 8'h00, 0, 0);

        for (int i = 0; i < 17; i++) begin
            cycle(vt[i].vin, vt[i].din, vt[i].rout, vt[i].fl);
            check("vec_count", 32'(count),        32'(vt[i].e_count));
            check("vec_valid", 32'(valid_out),    32'(vt[i].e_valid));
            check("vec_ready", 32'(ready_in),     32'(vt[i].e_ready));
            check("vec_af",    32'(almost_full),  32'(vt[i].e_af));
            check("vec_ae",    32'(almost_empty), 32'(vt[i].e_ae));
            if (vt[i].e_valid) check("vec_data", 32'(data_out), 32'(vt[i].e_data));
`ifdef SYNC_FIFO_WATERMARK_EN
            if (i == 8) check("hw_after_fill", 32'(high_water), 32'd8);
`endif
        end

        // Steady state at count 4 with pointers already wrapped once.
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'h44 + i), 1, 0);
            check("steady_count", 32'(count), 32'd4);
        end

        // Flush at count 5 together with a push of 0xAA.
        cycle(1, 8'h60, 0, 0);
        check("count_before_flush", 32'(count), 32'd5);
        valid_in = 1'b1; data_in = 8'hAA; flush = 1'b1;
        #1;
        check("ready_during_flush", 32'(ready_in), 32'd1);
        cycle(1, 8'hAA, 0, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(valid_out), 32'd0);
`ifdef SYNC_FIFO_WATERMARK_EN
        check("hw_after_flush", 32'(high_water), 32'd0);
`endif
        aa_banned = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h70 + i), 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        check("no_aa_after_flush", 32'(seen_aa), 32'd0);
        aa_banned = 1'b0;

        // Asynchronous reset in the middle of a cycle at count 3.
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h30 + i), 0, 0);
        check("count_before_reset", 32'(count), 32'd3);
        valid_in = 1'b1; data_in = 8'h99; ready_out = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(valid_out), 32'd0);
        check("async_ready", 32'(ready_in),  32'd0);
        check("async_count", 32'(count),     32'd0);
        mq.delete(); m_active = 1'b0; m_hw = 0;
        #2;
        reset_n = 1'b1;
        #1;
        check_all();
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);

        // Randomized traffic: fill-leaning phase then drain-leaning phase, rare flushes.
        for (int i = 0; i < 400; i++) begin
            bit vin, rout, fl;
            vin  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rout = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            cycle(vin, 8'($urandom), rout, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
